// File: rtl/fir_pkg.sv
// Shared definitions for the sequential FIR MAC: controller state encoding,
// default geometry and the sample/coefficient/product widths.
package fir_pkg;

    localparam int unsigned NUM_TAPS_DEF  = 1021;
    localparam int unsigned FRAC_BITS_DEF = 15;
    localparam int unsigned ACC_W_DEF     = 42;

    localparam int unsigned SMPL_W = 16;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned PROD_W = SMPL_W + COEF_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } fir_state_e;

endpackage

// File: rtl/fir_coeff_rom.sv
// Coefficient ROM: NUM_TAPS x 16-bit Q1.15 coefficients, synchronous read,
// one cycle of read latency.
// Contents come from the COEFFS parameter (coeff[i] at bits [16*i +: 16]);
// the integration flow builds that vector from the coefficient hex file.
// Addresses at or beyond NUM_TAPS read as zero.
// Ports:
//   clk      rising-edge clock
//   addr     tap index
//   rd_data  coefficient for the address presented on the previous edge
module fir_coeff_rom
    import fir_pkg::*;
#(
    parameter int unsigned                NUM_TAPS = NUM_TAPS_DEF,
    parameter int unsigned                ADDR_W   = $clog2(NUM_TAPS + 1),
    parameter logic [NUM_TAPS*COEF_W-1:0] COEFFS   = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [COEF_W-1:0] rd_data
);

    localparam int unsigned IDX_W = $clog2(NUM_TAPS * COEF_W);

    logic [COEF_W-1:0] rd_data_d;
    logic [COEF_W-1:0] rd_data_q;

    // Table lookup with an out-of-range guard
    always_comb begin
        rd_data_d = '0;
        if (addr < ADDR_W'(NUM_TAPS)) begin
            rd_data_d = COEFFS[IDX_W'(addr) * IDX_W'(COEF_W) +: COEF_W];
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_seq_mac.sv
// Sequential single-MAC FIR filter. Each burst of NUM_TAPS samples read from
// an external queue is multiplied against the coefficient ROM and accumulated;
// the scaled sum is published on smpl_out with a one-cycle smpl_vld pulse.
// A burst that ends early raises a one-cycle abort pulse instead.
// Output reduction: define FIR_SAT_EN to saturate the scaled sum to 16 bits;
// by default the low 16 bits are kept (wrap).
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   sequencing  queue read burst active (NUM_TAPS cycles per burst)
//   smpl_in     queue read data, one cycle after each sequencing-high cycle
//   smpl_out    filtered sample, held until the next update
//   smpl_vld    one-cycle pulse when smpl_out updates
//   busy        burst in progress (accumulating or publishing)
//   abort       one-cycle pulse when a burst ends short
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int unsigned                NUM_TAPS  = NUM_TAPS_DEF,
    parameter int unsigned                FRAC_BITS = FRAC_BITS_DEF,
    parameter int unsigned                ACC_W     = ACC_W_DEF,
    parameter logic [NUM_TAPS*COEF_W-1:0] COEFFS    =
        {{((NUM_TAPS - 1) * COEF_W){1'b0}}, 16'h4000}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sequencing,
    input  logic signed [SMPL_W-1:0] smpl_in,
    output logic signed [SMPL_W-1:0] smpl_out,
    output logic                     smpl_vld,
    output logic                     busy,
    output logic                     abort
);

    localparam int unsigned CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SMPL_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

    fir_state_e                state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          tap_cnt_q, tap_cnt_d;
    logic signed [SMPL_W-1:0]  smpl_out_q, smpl_out_d;
    logic                      smpl_vld_q, smpl_vld_d;
    logic                      busy_q, busy_d;
    logic                      abort_q, abort_d;
    logic                      seq_d1_q, seq_d1_d;

    logic signed [COEF_W-1:0]  coeff;
    logic signed [PROD_W-1:0]  prod_c;
    logic                      seq_rise_c;

    // Scale the accumulator back to Q1.15 and reduce it to the output width
    function automatic logic signed [SMPL_W-1:0] scale_out(
        input logic signed [ACC_W-1:0] acc
    );
`ifdef FIR_SAT_EN
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC_BITS;
        if (sh > SAT_MAX) begin
            scale_out = {1'b0, {(SMPL_W - 1){1'b1}}};
        end else if (sh < SAT_MIN) begin
            scale_out = {1'b1, {(SMPL_W - 1){1'b0}}};
        end else begin
            scale_out = sh[SMPL_W-1:0];
        end
`else
        scale_out = SMPL_W'(acc >>> FRAC_BITS);
`endif
    endfunction

    // Address is the tap count after this cycle's MAC, so the coefficient
    // issued in a sequencing-high cycle lines up with that cycle's sample.
    fir_coeff_rom #(
        .NUM_TAPS (NUM_TAPS),
        .ADDR_W   (CNT_W),
        .COEFFS   (COEFFS)
    ) u_coeff_rom (
        .clk      (clk),
        .addr     (tap_cnt_d),
        .rd_data  (coeff)
    );

    assign prod_c     = PROD_W'(smpl_in) * PROD_W'(coeff);
    assign seq_rise_c = sequencing & ~seq_d1_q;

    // Burst controller and datapath next-state
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        tap_cnt_d  = tap_cnt_q;
        smpl_out_d = smpl_out_q;
        smpl_vld_d = 1'b0;
        abort_d    = 1'b0;
        seq_d1_d   = sequencing;

        case (state_q)
            ST_IDLE: begin
                acc_d     = '0;
                tap_cnt_d = '0;
                if (seq_rise_c) begin
                    state_d = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (seq_d1_q) begin
                    acc_d     = acc_q + ACC_W'(prod_c);
                    tap_cnt_d = tap_cnt_q + CNT_W'(1);
                    if (tap_cnt_q == LAST_TAP) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    // Data stopped before the last tap: drop the partial sum
                    abort_d   = 1'b1;
                    acc_d     = '0;
                    tap_cnt_d = '0;
                    state_d   = seq_rise_c ? ST_ACCUM : ST_IDLE;
                end
            end

            ST_DONE: begin
                smpl_out_d = scale_out(acc_q);
                smpl_vld_d = 1'b1;
                acc_d      = '0;
                tap_cnt_d  = '0;
                // A new burst may start right here after a single low cycle
                if (seq_rise_c) begin
                    state_d = ST_ACCUM;
                end else if (sequencing) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                acc_d     = '0;
                tap_cnt_d = '0;
                if (!sequencing) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                acc_d     = '0;
                tap_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ACCUM) || (state_d == ST_DONE);
    end

    // State and output registers. seq_d1 resets high so that a sequencing
    // level already present when reset lifts is not taken as a new burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            tap_cnt_q  <= '0;
            smpl_out_q <= '0;
            smpl_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            abort_q    <= 1'b0;
            seq_d1_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tap_cnt_q  <= tap_cnt_d;
            smpl_out_q <= smpl_out_d;
            smpl_vld_q <= smpl_vld_d;
            busy_q     <= busy_d;
            abort_q    <= abort_d;
            seq_d1_q   <= seq_d1_d;
        end
    end

    assign smpl_out = smpl_out_q;
    assign smpl_vld = smpl_vld_q;
    assign busy     = busy_q;
    assign abort    = abort_q;

endmodule

// File: tb/tb_fir_seq_mac.sv
// Bench for fir_seq_mac: two instances share one stimulus stream, one with an
// impulse coefficient set (coeff[0]=0x4000) and one with all 0x7FFF.
module tb_fir_seq_mac;

    localparam int unsigned N  = 1021;
    localparam int unsigned FB = 15;
    localparam logic [N*16-1:0] COEF_IMP = {{((N - 1) * 16){1'b0}}, 16'h4000};
    localparam logic [N*16-1:0] COEF_MAX = {N{16'h7FFF}};

    logic clk = 1'b0;
    logic rst;
    logic sequencing;
    logic signed [15:0] smpl_in;

    logic signed [15:0] out_imp, out_max;
    logic vld_imp, vld_max, busy_imp, busy_max, abort_imp, abort_max;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int                 cyc;
        logic signed [15:0] imp;
        logic signed [15:0] mx;
    } exp_t;

    exp_t exp_q[$];
    int   ab_q[$];
    exp_t e;
    logic signed [15:0] last_imp = '0;
    logic signed [15:0] last_max = '0;

    fir_seq_mac #(.NUM_TAPS(N), .FRAC_BITS(FB), .ACC_W(42), .COEFFS(COEF_IMP)) dut_imp (
        .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in),
        .smpl_out(out_imp), .smpl_vld(vld_imp), .busy(busy_imp), .abort(abort_imp)
    );

    fir_seq_mac #(.NUM_TAPS(N), .FRAC_BITS(FB), .ACC_W(42), .COEFFS(COEF_MAX)) dut_max (
        .clk(clk), .rst(rst), .sequencing(sequencing), .smpl_in(smpl_in),
        .smpl_out(out_max), .smpl_vld(vld_max), .busy(busy_max), .abort(abort_max)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference output reduction
    function automatic logic signed [15:0] reduce(input longint acc);
        longint sh;
        sh = acc >>> FB;
`ifdef FIR_SAT_EN
        if (sh > 32767)  return 16'sh7FFF;
        if (sh < -32768) return 16'sh8000;
`endif
        return 16'(sh);
    endfunction

    // Sample j of a burst: mode 1 = all 0x7FFF, 2 = all 0x8000, else random
    function automatic logic signed [15:0] smp(input int mode, input int j, input int s0);
        if (j == 0)    return 16'(s0);
        if (mode == 1) return 16'sh7FFF;
        if (mode == 2) return 16'sh8000;
        return 16'($urandom);
    endfunction

    // Drive one burst of n sequencing-high cycles plus the trailing data cycle
    task automatic run_burst(input int n, input int mode, input int s0);
        longint a_imp, a_max;
        int st;
        logic signed [15:0] cur;
        exp_t x;
        a_imp = 0;
        a_max = 0;
        st    = 0;
        cur   = '0;
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            if (k == 0) st = cyc;
            sequencing = (k < n);
            if (k > 0) begin
                smpl_in = cur;
                if (k - 1 < int'(N)) begin
                    if (k == 1) a_imp = longint'(cur) * 16384;
                    a_max += longint'(cur) * 32767;
                end
            end
            if (k < n) cur = smp(mode, k, s0);
            if (k == 2 && n > 2) begin
                chk("busy_mid_imp", busy_imp, 1);
                chk("busy_mid_max", busy_max, 1);
            end
            if (n >= int'(N) && k == int'(N)) begin
                x.cyc = st + int'(N) + 2;
                x.imp = reduce(a_imp);
                x.mx  = reduce(a_max);
                exp_q.push_back(x);
                last_imp = x.imp;
                last_max = x.mx;
            end
            if (n > int'(N) + 10 && k == int'(N) + 10) begin
                chk("drain_busy_imp", busy_imp, 0);
                chk("drain_busy_max", busy_max, 0);
            end
        end
        if (n < int'(N)) ab_q.push_back(st + n + 2);
    endtask

    // Output monitor: pops the scoreboard on every smpl_vld / abort pulse
    always @(negedge clk) begin
        if (vld_imp === 1'b1 || vld_max === 1'b1) begin
            chk("vld_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("vld_cycle", cyc, e.cyc);
                chk("vld_imp", vld_imp, 1);
                chk("vld_max", vld_max, 1);
                chk("out_imp", out_imp, e.imp);
                chk("out_max", out_max, e.mx);
            end
        end
        if (abort_imp === 1'b1 || abort_max === 1'b1) begin
            chk("abort_expected", ab_q.size() != 0, 1);
            if (ab_q.size() != 0) begin
                chk("abort_cycle", cyc, ab_q.pop_front());
                chk("abort_imp", abort_imp, 1);
                chk("abort_max", abort_max, 1);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        sequencing = 1'b1;
        smpl_in    = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_imp",   out_imp, 0);
        chk("rst_out_max",   out_max, 0);
        chk("rst_vld_imp",   vld_imp, 0);
        chk("rst_busy_imp",  busy_imp, 0);
        chk("rst_abort_imp", abort_imp, 0);

        // sequencing already high when reset lifts must not start a burst
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("stale_seq_busy", busy_imp, 0);
        sequencing = 1'b0;
        repeat (3) @(negedge clk);

        // Impulse response check, then full-scale positive and negative bursts
        run_burst(int'(N), 0, 1000);
        repeat (4) @(negedge clk);
        chk("hold_imp_500", out_imp, 500);
        run_burst(int'(N), 1, 32767);
        repeat (4) @(negedge clk);
        run_burst(int'(N), 2, -1001);
        repeat (4) @(negedge clk);

        // Short burst: abort, previous output retained
        run_burst(500, 0, 77);
        repeat (5) @(negedge clk);
        chk("abort_hold_imp", out_imp, last_imp);
        chk("abort_hold_max", out_max, last_max);
        chk("abort_busy", busy_imp, 0);

        // Over-long burst: single output then drain
        run_burst(1100, 0, -5);
        repeat (4) @(negedge clk);
        chk("post_drain_busy", busy_max, 0);

        // Reset at tap 300 discards the burst
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk);
            sequencing = 1'b1;
            smpl_in    = 16'($urandom);
            if (k == 300) rst = 1'b1;
        end
        @(negedge clk);
        chk("mid_rst_out_imp",   out_imp, 0);
        chk("mid_rst_out_max",   out_max, 0);
        chk("mid_rst_vld_max",   vld_max, 0);
        chk("mid_rst_busy_max",  busy_max, 0);
        chk("mid_rst_abort_max", abort_max, 0);
        rst = 1'b0;
        repeat (800) @(negedge clk);
        sequencing = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_rst_idle_busy", busy_imp, 0);

        run_burst(int'(N), 0, 4242);
        repeat (4) @(negedge clk);

        // Back-to-back bursts with one low cycle between
        run_burst(int'(N), 0, -20000);
        run_burst(int'(N), 0, 12345);
        repeat (6) @(negedge clk);

        chk("sb_empty", exp_q.size(), 0);
        chk("abort_q_empty", ab_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
